// File: rtl/dram_bank_responder.sv
// dram_bank_responder: target-side model of a DRAM command interface.
// Tracks one open row per bank, stores column words in an internal array and
// moves data over a one-bit serial line (MSB first) with a four-phase
// cmd_req/cmd_ack handshake.
// Optional feature: define DRAM_RSP_ONEHOT_CHECK_EN to reject any used select
// that is not exactly one-hot (err pulse, ack, no effect).
module dram_bank_responder #(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_OF_BANKS = 8,
   parameter int NUM_OF_ROWS  = 128,
   parameter int NUM_OF_COLS  = 8,
   parameter int ACT_LAT      = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_req,
   input  logic [1:0]              cmd,
   input  logic [NUM_OF_BANKS-1:0] bank_sel,
   input  logic [NUM_OF_ROWS-1:0]  row_sel,
   input  logic [NUM_OF_COLS-1:0]  col_sel,
   input  logic                    dram_data_in,
   output logic                    dram_data_out,
   output logic                    dram_data_oe,
   output logic                    cmd_ack,
   output logic                    err
);

   localparam int BANK_W = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
   localparam int ROW_W  = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;
   localparam int COL_W  = (NUM_OF_COLS > 1) ? $clog2(NUM_OF_COLS) : 1;
   localparam int SEL_W0 = (NUM_OF_BANKS > NUM_OF_ROWS) ? NUM_OF_BANKS : NUM_OF_ROWS;
   localparam int SEL_W  = (SEL_W0 > NUM_OF_COLS) ? SEL_W0 : NUM_OF_COLS;
   localparam int CNT_W  = $clog2(DATA_WIDTH + 16);

   // Last count value of each timed state; ACT_WAIT spends ACT_LAT-1 cycles.
   localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'((ACT_LAT > 1) ? ACT_LAT - 2 : 0);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

   localparam logic [1:0] CMD_PRE = 2'b00;
   localparam logic [1:0] CMD_ACT = 2'b01;
   localparam logic [1:0] CMD_WR  = 2'b10;
   localparam logic [1:0] CMD_RD  = 2'b11;

   typedef enum logic [2:0] {ST_IDLE, ST_ACT_WAIT, ST_WR_SHIFT, ST_RD_SHIFT, ST_ACK} state_e;
   typedef enum logic [1:0] {SH_HOLD, SH_LOAD, SH_IN, SH_OUT} shift_op_e;

   // Lowest set bit wins; an all-zero select encodes to index 0.
   function automatic int lsb_index(input logic [SEL_W-1:0] sel);
      int idx;
      idx = 0;
      for (int i = SEL_W - 1; i >= 0; i--) begin
         if (sel[i]) idx = i;
      end
      return idx;
   endfunction

`ifdef DRAM_RSP_ONEHOT_CHECK_EN
   function automatic logic is_onehot(input logic [SEL_W-1:0] sel);
      return (sel != '0) && ((sel & (sel - SEL_W'(1))) == '0);
   endfunction
`endif

   // Control state
   state_e                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_ack;
   logic                   r_err;
   logic                   r_oe;
   logic [NUM_OF_BANKS-1:0] r_open_vld;
   logic [ROW_W-1:0]       r_open_row [NUM_OF_BANKS];

   // Datapath state
   logic [DATA_WIDTH-1:0]  r_sh;
   logic [BANK_W-1:0]      r_bank;
   logic [ROW_W-1:0]       r_row;
   logic [COL_W-1:0]       r_col;
   logic [DATA_WIDTH-1:0]  r_mem [NUM_OF_BANKS][NUM_OF_ROWS][NUM_OF_COLS];

   // Combinational signals
   state_e                 w_state_nxt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   w_ack_nxt;
   logic                   w_err_nxt;
   logic                   w_oe_nxt;
   shift_op_e              w_sh_op;
   logic                   w_mem_we;
   logic                   w_tbl_set;
   logic                   w_tbl_clr;
   logic                   w_accept;
   logic                   w_sel_bad;
   logic                   w_bank_open;
   logic [BANK_W-1:0]      w_bank_idx;
   logic [ROW_W-1:0]       w_row_idx;
   logic [COL_W-1:0]       w_col_idx;
   logic [ROW_W-1:0]       w_open_row;
   logic [DATA_WIDTH-1:0]  w_wdata;

   assign w_bank_idx  = BANK_W'(lsb_index(SEL_W'(bank_sel)));
   assign w_row_idx   = ROW_W'(lsb_index(SEL_W'(row_sel)));
   assign w_col_idx   = COL_W'(lsb_index(SEL_W'(col_sel)));
   assign w_bank_open = r_open_vld[w_bank_idx];
   assign w_open_row  = r_open_row[w_bank_idx];
   assign w_accept    = (r_state == ST_IDLE) && cmd_req;
   assign w_wdata     = {r_sh[DATA_WIDTH-2:0], dram_data_in};

`ifdef DRAM_RSP_ONEHOT_CHECK_EN
   assign w_sel_bad = !is_onehot(SEL_W'(bank_sel))
                   || ((cmd == CMD_ACT) && !is_onehot(SEL_W'(row_sel)))
                   || (cmd[1] && !is_onehot(SEL_W'(col_sel)));
`else
   assign w_sel_bad = 1'b0;
`endif

   // Next-state and next-output decode for the command FSM.
   // NOTE: every signal gets a default first so no branch can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ack_nxt   = r_ack;
      w_err_nxt   = 1'b0;
      w_oe_nxt    = r_oe;
      w_sh_op     = SH_HOLD;
      w_mem_we    = 1'b0;
      w_tbl_set   = 1'b0;
      w_tbl_clr   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (cmd_req) begin
               w_cnt_nxt = '0;
               if (w_sel_bad) begin
                  w_err_nxt   = 1'b1;
                  w_ack_nxt   = 1'b1;
                  w_state_nxt = ST_ACK;
               end else begin
                  unique case (cmd)
                     CMD_PRE: begin
                        w_tbl_clr   = 1'b1;
                        w_ack_nxt   = 1'b1;
                        w_state_nxt = ST_ACK;
                     end
                     CMD_ACT: begin
                        if (!w_bank_open) begin
                           w_tbl_set = 1'b1;
                           if (ACT_LAT == 1) begin
                              w_ack_nxt   = 1'b1;
                              w_state_nxt = ST_ACK;
                           end else begin
                              w_state_nxt = ST_ACT_WAIT;
                           end
                        end else begin
                           // Same row is a harmless no-op; a different row is a conflict.
                           w_err_nxt   = (w_open_row != w_row_idx);
                           w_ack_nxt   = 1'b1;
                           w_state_nxt = ST_ACK;
                        end
                     end
                     CMD_WR: begin
                        if (!w_bank_open) begin
                           w_err_nxt   = 1'b1;
                           w_ack_nxt   = 1'b1;
                           w_state_nxt = ST_ACK;
                        end else begin
                           w_state_nxt = ST_WR_SHIFT;
                        end
                     end
                     default: begin
                        if (!w_bank_open) begin
                           w_err_nxt   = 1'b1;
                           w_ack_nxt   = 1'b1;
                           w_state_nxt = ST_ACK;
                        end else begin
                           w_sh_op     = SH_LOAD;
                           w_oe_nxt    = 1'b1;
                           w_state_nxt = ST_RD_SHIFT;
                        end
                     end
                  endcase
               end
            end
         end
         ST_ACT_WAIT: begin
            if (r_cnt == ACT_LAST) begin
               w_ack_nxt   = 1'b1;
               w_state_nxt = ST_ACK;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_WR_SHIFT: begin
            w_sh_op = SH_IN;
            if (r_cnt == BIT_LAST) begin
               w_mem_we    = 1'b1;
               w_ack_nxt   = 1'b1;
               w_state_nxt = ST_ACK;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_RD_SHIFT: begin
            if (r_cnt == BIT_LAST) begin
               w_oe_nxt    = 1'b0;
               w_ack_nxt   = 1'b1;
               w_state_nxt = ST_ACK;
            end else begin
               w_sh_op   = SH_OUT;
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_ACK: begin
            if (!cmd_req) begin
               w_ack_nxt   = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Control registers and the open-row table; reset closes every bank.
   // NOTE: sequential state uses <= so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_oe       <= 1'b0;
         r_open_vld <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
         r_oe    <= w_oe_nxt;
         if (w_tbl_set) begin
            r_open_vld[w_bank_idx] <= 1'b1;
            r_open_row[w_bank_idx] <= w_row_idx;
         end
         if (w_tbl_clr) begin
            r_open_vld[w_bank_idx] <= 1'b0;
         end
      end
   end

   // Address latch, serial shift register and word storage.
   // NOTE: the array, shift register and latched address carry no reset; only
   // the write enable is gated so a reset edge can never commit a partial word.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_bank <= w_bank_idx;
         r_row  <= w_open_row;
         r_col  <= w_col_idx;
      end
      unique case (w_sh_op)
         SH_LOAD: r_sh <= r_mem[w_bank_idx][w_open_row][w_col_idx];
         SH_IN:   r_sh <= w_wdata;
         SH_OUT:  r_sh <= {r_sh[DATA_WIDTH-2:0], 1'b0};
         default: r_sh <= r_sh;
      endcase
      if (w_mem_we && !rst) begin
         r_mem[r_bank][r_row][r_col] <= w_wdata;
      end
   end

   assign cmd_ack       = r_ack;
   assign err           = r_err;
   assign dram_data_oe  = r_oe;
   assign dram_data_out = r_oe & r_sh[DATA_WIDTH-1];

endmodule
